// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: shadow-stage record, FSM states
// and the ID-stage capture rule.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // One shadow pipeline slot: destination tag plus the control bits the
  // forwarding unit and the hazard logic care about.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_access;
    logic             valid;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Build the ID/EX record from decoder fields. An empty ID slot becomes a
  // bubble, and x0 is never tracked as a written register.
  function automatic stage_t capture_id(
    input logic             valid,
    input logic [REG_W-1:0] rd,
    input logic             reg_write,
    input logic             mem_to_reg,
    input logic             mem_access
  );
    stage_t s;
    s = STAGE_BUBBLE;
    if (valid) begin
      s.rd         = rd;
      s.reg_write  = reg_write && (rd != '0);
      s.mem_to_reg = mem_to_reg;
      s.mem_access = mem_access;
      s.valid      = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline register: loads on advance (or loads a bubble), holds
// otherwise.
module hazard_shadow_stage
  import hazard_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  // Stage register with synchronous reset, advance and bubble insertion.
  // NOTE: reset is sampled only on the clock edge; every flop here gets a
  // defined value since there is no storage array to leave unreset.
  // NOTE: sequential state uses <= so all three stages shift together on the
  // same edge instead of racing each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= STAGE_BUBBLE;
    end else if (advance) begin
      q <= bubble ? STAGE_BUBBLE : d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow destination-tag pipeline for forwarding,
// load-use stalls, taken-branch flushes and data-memory wait freezes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_MemAccess,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic [REG_W-1:0] ex_mem_WriteReg,
  output logic [REG_W-1:0] mem_wb_WriteReg,
  output logic             ex_mem_RegWrite,
  output logic             ex_mem_MemtoReg,
  output logic             mem_wb_RegWrite,
  output logic             mem_wb_MemtoReg,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  stage_t            id_stage;
  stage_t            id_ex;
  stage_t            ex_mem;
  stage_t            mem_wb;
  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              timeout_next;
  logic              freeze;
  logic              flush;
  logic              load_use;
  logic              rs_hit;
  logic              advance;

  assign id_stage = capture_id(id_valid, id_rd, id_RegWrite, id_MemtoReg, id_MemAccess);

  // Hazard decode with priority freeze > flush > load-use.
  // NOTE: every signal written here gets a value on every path, otherwise
  // synthesis infers a latch to remember the old one.
  always_comb begin
    rs_hit   = (id_uses_rs1 && (id_rs1 == id_ex.rd)) ||
               (id_uses_rs2 && (id_rs2 == id_ex.rd));
    freeze   = ex_mem.mem_access && !mem_ready;
    flush    = ex_branch_taken && !freeze;
    load_use = !freeze && !flush && id_ex.mem_to_reg && (id_ex.rd != '0) &&
               id_valid && rs_hit;
  end

  assign advance      = !freeze;
  assign pipe_freeze  = freeze;
  assign pc_stall     = freeze || load_use;
  assign if_id_stall  = freeze || load_use;
  assign id_ex_bubble = flush || load_use;
  assign if_id_flush  = flush;

  hazard_shadow_stage u_id_ex (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .bubble  (id_ex_bubble),
    .d       (id_stage),
    .q       (id_ex)
  );

  hazard_shadow_stage u_ex_mem (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .bubble  (1'b0),
    .d       (id_ex),
    .q       (ex_mem)
  );

  hazard_shadow_stage u_mem_wb (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .bubble  (1'b0),
    .d       (ex_mem),
    .q       (mem_wb)
  );

  assign ex_mem_WriteReg = ex_mem.rd;
  assign ex_mem_RegWrite = ex_mem.reg_write;
  assign ex_mem_MemtoReg = ex_mem.mem_to_reg;
  assign mem_wb_WriteReg = mem_wb.rd;
  assign mem_wb_RegWrite = mem_wb.reg_write;
  assign mem_wb_MemtoReg = mem_wb.mem_to_reg;

  // The writeback slot only feeds forwarding tags; its access/valid bits
  // have no consumer.
  logic unused_mem_wb;
  assign unused_mem_wb = mem_wb.mem_access ^ mem_wb.valid;

  // Wait FSM state, wait counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      mem_timeout <= timeout_next;
    end
  end

  // Next-state logic: count cycles spent waiting on data memory; the timeout
  // flags the condition but does not force the FSM out of MEM_WAIT.
  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    timeout_next = mem_timeout;
    unique case (state)
      ST_RUN: begin
        wait_next = '0;
        if (freeze) state_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_next = ST_RUN;
          wait_next  = '0;
        end else begin
          if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_next = wait_cnt + 1'b1;
          if (wait_next == WAIT_W'(MAX_WAIT)) timeout_next = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (pc_stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a behavioural pipeline model compared
// every cycle, directed scenarios with literal expectations, then random
// traffic.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_RegWrite;
  logic             id_MemtoReg;
  logic             id_MemAccess;
  logic             ex_branch_taken;
  logic             mem_ready;
  logic [4:0]       ex_mem_WriteReg;
  logic [4:0]       mem_wb_WriteReg;
  logic             ex_mem_RegWrite;
  logic             ex_mem_MemtoReg;
  logic             mem_wb_RegWrite;
  logic             mem_wb_MemtoReg;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_RegWrite     (id_RegWrite),
    .id_MemtoReg     (id_MemtoReg),
    .id_MemAccess    (id_MemAccess),
    .ex_branch_taken (ex_branch_taken),
    .mem_ready       (mem_ready),
    .ex_mem_WriteReg (ex_mem_WriteReg),
    .mem_wb_WriteReg (mem_wb_WriteReg),
    .ex_mem_RegWrite (ex_mem_RegWrite),
    .ex_mem_MemtoReg (ex_mem_MemtoReg),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .mem_wb_MemtoReg (mem_wb_MemtoReg),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .pipe_freeze     (pipe_freeze),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  // Selectors for literal expectations queued by the stimulus.
  typedef enum int {
    S_PC_STALL, S_IF_ID_STALL, S_BUBBLE, S_FLUSH, S_FREEZE, S_TIMEOUT,
    S_STALL_CNT, S_EM_RD, S_EM_RW, S_EM_M2R, S_WB_RD, S_WB_RW
  } sel_t;

  function automatic logic [31:0] sig_val(input sel_t s);
    case (s)
      S_PC_STALL:    return 32'(pc_stall);
      S_IF_ID_STALL: return 32'(if_id_stall);
      S_BUBBLE:      return 32'(id_ex_bubble);
      S_FLUSH:       return 32'(if_id_flush);
      S_FREEZE:      return 32'(pipe_freeze);
      S_TIMEOUT:     return 32'(mem_timeout);
      S_STALL_CNT:   return 32'(stall_count);
      S_EM_RD:       return 32'(ex_mem_WriteReg);
      S_EM_RW:       return 32'(ex_mem_RegWrite);
      S_EM_M2R:      return 32'(ex_mem_MemtoReg);
      S_WB_RD:       return 32'(mem_wb_WriteReg);
      S_WB_RW:       return 32'(mem_wb_RegWrite);
      default:       return 32'hdead_beef;
    endcase
  endfunction

  // Literal expectations for the current cycle (written by stimulus only).
  string lit_name [8];
  sel_t  lit_sel  [8];
  int    lit_exp  [8];
  int    lit_n = 0;

  task automatic expect_lit(input string name, input sel_t s, input int e);
    lit_name[lit_n] = name;
    lit_sel[lit_n]  = s;
    lit_exp[lit_n]  = e;
    lit_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lit_n = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_RegWrite = 0; id_MemtoReg = 0; id_MemAccess = 0;
    ex_branch_taken = 0; mem_ready = 1;
  endtask

  task automatic put_id(input int rd, input bit rw, input bit m2r, input bit ma,
                        input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid = 1; id_rd = 5'(rd); id_RegWrite = rw; id_MemtoReg = m2r;
    id_MemAccess = ma; id_rs1 = 5'(rs1); id_uses_rs1 = u1;
    id_rs2 = 5'(rs2); id_uses_rs2 = u2;
  endtask

  // ---------------- behavioural model + compare process ----------------
  typedef struct {
    int rd;
    bit rw;
    bit m2r;
    bit ma;
  } ent_t;

  ent_t pipe [3];          // [0]=ID/EX [1]=EX/MEM [2]=MEM/WB
  int   frozen_streak = 0; // consecutive frozen cycles so far
  bit   m_timeout = 0;
  int   m_stalls = 0;
  bit   chk_en = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit   frz, fl, hit, lu, stall;
    ent_t nxt;
    ent_t empty;
    if (chk_en) begin
      empty = '{rd: 0, rw: 0, m2r: 0, ma: 0};
      frz   = pipe[1].ma && !mem_ready;
      fl    = ex_branch_taken && !frz;
      hit   = (id_uses_rs1 && int'(id_rs1) == pipe[0].rd) ||
              (id_uses_rs2 && int'(id_rs2) == pipe[0].rd);
      lu    = !frz && !fl && pipe[0].m2r && pipe[0].rd != 0 && id_valid && hit;
      stall = frz || lu;

      check("pc_stall",        32'(pc_stall),        32'(stall));
      check("if_id_stall",     32'(if_id_stall),     32'(stall));
      check("id_ex_bubble",    32'(id_ex_bubble),    32'(fl || lu));
      check("if_id_flush",     32'(if_id_flush),     32'(fl));
      check("pipe_freeze",     32'(pipe_freeze),     32'(frz));
      check("mem_timeout",     32'(mem_timeout),     32'(m_timeout));
      check("stall_count",     32'(stall_count),     32'(m_stalls));
      check("ex_mem_WriteReg", 32'(ex_mem_WriteReg), 32'(pipe[1].rd));
      check("ex_mem_RegWrite", 32'(ex_mem_RegWrite), 32'(pipe[1].rw));
      check("ex_mem_MemtoReg", 32'(ex_mem_MemtoReg), 32'(pipe[1].m2r));
      check("mem_wb_WriteReg", 32'(mem_wb_WriteReg), 32'(pipe[2].rd));
      check("mem_wb_RegWrite", 32'(mem_wb_RegWrite), 32'(pipe[2].rw));
      check("mem_wb_MemtoReg", 32'(mem_wb_MemtoReg), 32'(pipe[2].m2r));
      for (int i = 0; i < lit_n; i++)
        check(lit_name[i], sig_val(lit_sel[i]), 32'(lit_exp[i]));

      // Advance the model to what the next clock edge must produce.
      if (rst) begin
        for (int i = 0; i < 3; i++) pipe[i] = empty;
        frozen_streak = 0;
        m_timeout     = 0;
        m_stalls      = 0;
      end else begin
        if (stall && m_stalls < (1 << CNT_W) - 1) m_stalls++;
        if (frz) begin
          frozen_streak++;
          // First frozen cycle is spent in RUN; MAX_WAIT waiting cycles follow.
          if (frozen_streak > MAX_WAIT) m_timeout = 1;
        end else begin
          frozen_streak = 0;
        end
        if (!frz) begin
          nxt = empty;
          if (id_valid && !fl && !lu) begin
            nxt.rd  = int'(id_rd);
            nxt.rw  = id_RegWrite && id_rd != 0;
            nxt.m2r = id_MemtoReg;
            nxt.ma  = id_MemAccess;
          end
          pipe[2] = pipe[1];
          pipe[1] = pipe[0];
          pipe[0] = nxt;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int burst;
    burst = 0;
    idle();
    rst = 1;
    tick();
    chk_en = 1;
    expect_lit("reset_stall_count", S_STALL_CNT, 0);
    expect_lit("reset_ex_mem_rd",   S_EM_RD,     0);
    expect_lit("reset_timeout",     S_TIMEOUT,   0);
    tick();
    rst = 0;

    // Load-use: lw x5 in EX, add reads x5 in ID.
    put_id(5, 1, 1, 1, 0, 0, 0, 0);
    tick();
    idle(); put_id(6, 1, 0, 0, 5, 1, 0, 0);
    expect_lit("lu_pc_stall", S_PC_STALL, 1);
    expect_lit("lu_bubble",   S_BUBBLE,   1);
    tick();
    expect_lit("lu_ex_mem_rd",  S_EM_RD,    5);
    expect_lit("lu_ex_mem_m2r", S_EM_M2R,   1);
    expect_lit("lu_released",   S_PC_STALL, 0);
    tick();
    idle();

    // lw x0 is never a hazard and never marked as writing.
    put_id(0, 1, 1, 1, 0, 0, 0, 0);
    tick();
    idle(); put_id(7, 1, 0, 0, 0, 1, 0, 0);
    expect_lit("x0_no_stall", S_PC_STALL, 0);
    tick();
    idle();
    expect_lit("x0_ex_mem_rw", S_EM_RW, 0);
    tick();

    // Taken branch beats a simultaneous load-use condition.
    put_id(7, 1, 1, 1, 0, 0, 0, 0);
    tick();
    idle(); put_id(8, 1, 0, 0, 0, 0, 7, 1);
    ex_branch_taken = 1;
    expect_lit("br_flush",    S_FLUSH,    1);
    expect_lit("br_bubble",   S_BUBBLE,   1);
    expect_lit("br_no_stall", S_PC_STALL, 0);
    tick();
    idle();
    expect_lit("br_stall_count", S_STALL_CNT, 1);
    tick();

    // Store waits three cycles for data memory.
    put_id(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    idle(); put_id(9, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(); mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      expect_lit("sw_freeze",     S_FREEZE,    1);
      expect_lit("sw_hold_rd",    S_EM_RD,     0);
      expect_lit("sw_stall_cnt",  S_STALL_CNT, 1 + i);
      tick();
    end
    mem_ready = 1;
    expect_lit("sw_unfreeze",     S_FREEZE,    0);
    expect_lit("sw_stall_cnt_end", S_STALL_CNT, 4);
    tick();
    expect_lit("sw_advanced_rd", S_EM_RD, 9);
    expect_lit("sw_advanced_rw", S_EM_RW, 1);
    tick();

    // Memory stuck for 16 cycles: sticky timeout, cleared only by reset.
    put_id(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      expect_lit("to_freeze", S_FREEZE, 1);
      tick();
    end
    mem_ready = 1;
    expect_lit("to_set", S_TIMEOUT, 1);
    tick();
    expect_lit("to_sticky", S_TIMEOUT, 1);
    rst = 1;
    tick();
    rst = 0;
    expect_lit("to_cleared", S_TIMEOUT, 0);
    expect_lit("to_cnt_cleared", S_STALL_CNT, 0);
    tick();

    // Reset in the second MEM_WAIT cycle drops everything.
    put_id(4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(); put_id(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    idle(); put_id(8, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(); mem_ready = 0;
    expect_lit("rw_wb_rd_held", S_WB_RD, 4);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    expect_lit("rw_ex_mem_rd", S_EM_RD,     0);
    expect_lit("rw_wb_rd",     S_WB_RD,     0);
    expect_lit("rw_wb_rw",     S_WB_RW,     0);
    expect_lit("rw_no_freeze", S_FREEZE,    0);
    expect_lit("rw_stall_cnt", S_STALL_CNT, 0);
    tick();
    idle();

    // Random traffic with a small register set to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      id_RegWrite     = ($urandom_range(0, 3) != 0);
      id_MemtoReg     = ($urandom_range(0, 2) == 0);
      id_MemAccess    = id_MemtoReg || ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      if (burst > 0) begin
        mem_ready = 0;
        burst--;
      end else if ($urandom_range(0, 99) == 0) begin
        mem_ready = 0;
        burst = $urandom_range(15, 20);
      end else begin
        mem_ready = ($urandom_range(0, 5) != 0);
      end
      tick();
    end

    idle();
    rst = 0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
